rd_lvl_ctrl: RTL and testbench

Read-leveling controller for the PHY input-delay datapath. It sweeps the shared 4-bit per-line coarse input delay from 0 to MAX_DEL and issues NUM_RD training reads at each setting. Each returned byte is compared per line against a fixed pattern. The block then programs each line with the centre of its first contiguous passing window. It sits in the clk_div domain between the memory controller (training read requests) and the delay block's param_io_in_del/sync_en inputs.

---
 rtl/rd_lvl_ctrl_if.sv | 33 +++
 rtl/rd_lvl_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_rd_lvl_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rd_lvl_ctrl_if.sv
// ---------------------------------------------------------------------------
// rd_lvl_ctrl_if
// Training-read bus between the read-leveling controller and the memory
// controller / PHY data path.
//   trn_rd_req   : controller -> mc, training read request, held until ack
//   trn_rd_ack   : mc -> controller, request accepted this cycle
//   trn_rd_valid : phy -> controller, phy_dout carries read data this cycle
//   phy_dout     : phy -> controller, per-line bytes, line l at [8l+:8]
// The master modport is the side that issues requests (the leveling
// controller); the slave modport is the memory controller / PHY side.
// ---------------------------------------------------------------------------
interface rd_lvl_ctrl_if #(
  parameter int LINES = 16
);
  logic                 trn_rd_req;
  logic                 trn_rd_ack;
  logic                 trn_rd_valid;
  logic [8*LINES-1:0]   phy_dout;

  modport master (
    output trn_rd_req,
    input  trn_rd_ack,
    input  trn_rd_valid,
    input  phy_dout
  );

  modport slave (
    input  trn_rd_req,
    output trn_rd_ack,
    output trn_rd_valid,
    output phy_dout
  );
endinterface

// File: rtl/rd_lvl_ctrl.sv
// ---------------------------------------------------------------------------
// rd_lvl_ctrl
// Read-leveling controller. Sweeps the shared 4-bit coarse input delay from
// 0 to MAX_DEL, issues NUM_RD training reads per setting, compares every
// returned byte against PATTERN per line and finally programs each line with
// the centre of its first contiguous passing window.
// Ports:
//   clk_div, rst_div_n : clock, asynchronous active-low reset
//   train_start        : one-cycle pulse, starts a sweep from IDLE/DONE/FAIL
//   trn                : training-read bus (master side)
//   param_io_in_del    : per-line coarse delay, line l at [4l+:4]
//   sync_en            : PHY data synchronizer enable
//   train_busy         : sweep in progress
//   train_done         : finished, every line has a window
//   train_fail         : a line had no window, or a read timed out
//   fail_mask          : lines without any passing setting
//   timeout_err        : read data did not arrive within TIMEOUT cycles
// ---------------------------------------------------------------------------
module rd_lvl_ctrl #(
  parameter int         LINES      = 16,
  parameter int         MAX_DEL    = 4,
  parameter int         NUM_RD     = 4,
  parameter int         SETTLE_CYC = 8,
  parameter int         TIMEOUT    = 255,
  parameter logic [7:0] PATTERN    = 8'hA5
) (
  input  logic               clk_div,
  input  logic               rst_div_n,
  input  logic               train_start,
  rd_lvl_ctrl_if.master      trn,
  output logic [4*LINES-1:0] param_io_in_del,
  output logic               sync_en,
  output logic               train_busy,
  output logic               train_done,
  output logic               train_fail,
  output logic [LINES-1:0]   fail_mask,
  output logic               timeout_err
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(NUM_RD + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SET, S_SETTLE, S_REQ, S_WAIT, S_EVAL, S_APPLY, S_DONE, S_FAIL
  } state_t;

  state_t           state_reg;
  logic [3:0]       cur_del_reg;
  logic [SW-1:0]    settle_cnt_reg;
  logic [TW-1:0]    tmo_cnt_reg;
  logic [RW-1:0]    rd_cnt_reg;
  logic             req_reg;
  logic             sync_en_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             fail_reg;
  logic             tmo_err_reg;

  logic             start_go;
  logic             settle_end;
  logic [LINES-1:0] seen_vec;

  // A start pulse is only honoured while no sweep is running.
  assign start_go   = train_start &&
                      (state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_FAIL);
  assign settle_end = (state_reg == S_SETTLE) && (settle_cnt_reg == SW'(SETTLE_CYC - 1));

  assign trn.trn_rd_req = req_reg;
  assign sync_en        = sync_en_reg;
  assign train_busy     = busy_reg;
  assign train_done     = done_reg;
  assign train_fail     = fail_reg;
  assign timeout_err    = tmo_err_reg;

  // Sweep sequencer; all handshake and status outputs are registered here.
  always_ff @(posedge clk_div or negedge rst_div_n) begin
    if (!rst_div_n) begin
      state_reg      <= S_IDLE;
      cur_del_reg    <= '0;
      settle_cnt_reg <= '0;
      tmo_cnt_reg    <= '0;
      rd_cnt_reg     <= '0;
      req_reg        <= 1'b0;
      sync_en_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      fail_reg       <= 1'b0;
      tmo_err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE, S_FAIL: begin
          if (train_start) begin
            state_reg   <= S_SET;
            cur_del_reg <= '0;
            done_reg    <= 1'b0;
            fail_reg    <= 1'b0;
            tmo_err_reg <= 1'b0;
            busy_reg    <= 1'b1;
          end
        end
        S_SET: begin
          sync_en_reg    <= 1'b1;
          settle_cnt_reg <= '0;
          state_reg      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_end) begin
            rd_cnt_reg <= '0;
            req_reg    <= 1'b1;
            state_reg  <= S_REQ;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        S_REQ: begin
          // Read data seen before (or together with) ack is not ours.
          if (trn.trn_rd_ack) begin
            req_reg     <= 1'b0;
            tmo_cnt_reg <= '0;
            state_reg   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (trn.trn_rd_valid) begin
            rd_cnt_reg <= rd_cnt_reg + 1'b1;
            if (rd_cnt_reg == RW'(NUM_RD - 1)) begin
              state_reg <= S_EVAL;
            end else begin
              req_reg   <= 1'b1;
              state_reg <= S_REQ;
            end
          end else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
            tmo_err_reg <= 1'b1;
            fail_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            sync_en_reg <= 1'b0;
            state_reg   <= S_FAIL;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        S_EVAL: begin
          if (cur_del_reg < 4'(MAX_DEL)) begin
            cur_del_reg <= cur_del_reg + 1'b1;
            state_reg   <= S_SET;
          end else begin
            state_reg <= S_APPLY;
          end
        end
        S_APPLY: begin
          busy_reg <= 1'b0;
          if (&seen_vec) begin
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            fail_reg    <= 1'b1;
            sync_en_reg <= 1'b0;
            state_reg   <= S_FAIL;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Per-line window tracking and delay programming.
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      logic       seen_reg;
      logic       closed_reg;
      logic       trial_pass_reg;
      logic       mask_reg;
      logic [3:0] first_reg;
      logic [3:0] last_reg;
      logic [3:0] del_reg;
      logic       byte_ok;
      logic [4:0] win_sum;

      assign byte_ok = (trn.phy_dout[8*gi +: 8] == PATTERN);
      assign win_sum = {1'b0, first_reg} + {1'b0, last_reg};

      assign seen_vec[gi]              = seen_reg;
      assign fail_mask[gi]             = mask_reg;
      assign param_io_in_del[4*gi +: 4] = del_reg;

      always_ff @(posedge clk_div or negedge rst_div_n) begin
        if (!rst_div_n) begin
          seen_reg       <= 1'b0;
          closed_reg     <= 1'b0;
          trial_pass_reg <= 1'b0;
          mask_reg       <= 1'b0;
          first_reg      <= '0;
          last_reg       <= '0;
          del_reg        <= '0;
        end else begin
          if (start_go) begin
            seen_reg   <= 1'b0;
            closed_reg <= 1'b0;
            mask_reg   <= 1'b0;
          end
          case (state_reg)
            S_SET:    del_reg <= cur_del_reg;
            S_SETTLE: if (settle_end) trial_pass_reg <= 1'b1;
            S_WAIT:   if (trn.trn_rd_valid) trial_pass_reg <= trial_pass_reg & byte_ok;
            S_EVAL: begin
              // Only the first contiguous passing window is kept; once a
              // failing setting closes it, later passes are ignored.
              if (trial_pass_reg) begin
                if (!seen_reg) begin
                  first_reg <= cur_del_reg;
                  last_reg  <= cur_del_reg;
                  seen_reg  <= 1'b1;
                end else if (!closed_reg) begin
                  last_reg <= cur_del_reg;
                end
              end else if (seen_reg) begin
                closed_reg <= 1'b1;
              end
            end
            S_APPLY: begin
              // Window centre, rounded down.
              del_reg  <= seen_reg ? win_sum[4:1] : 4'd0;
              mask_reg <= ~seen_reg;
            end
            default: ;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_rd_lvl_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rd_lvl_ctrl
// Directed scenarios for the read-leveling controller. A small memory model
// answers training reads from a per-line pass table; expected end-of-sweep
// results are queued by the stimulus and checked by a monitor whenever the
// controller leaves the busy state.
// ---------------------------------------------------------------------------
module tb_rd_lvl_ctrl;
  localparam int LINES = 16;

  logic               clk_div   = 1'b0;
  logic               rst_div_n = 1'b0;
  logic               train_start = 1'b0;
  logic [4*LINES-1:0] param_io_in_del;
  logic               sync_en, train_busy, train_done, train_fail, timeout_err;
  logic [LINES-1:0]   fail_mask;

  rd_lvl_ctrl_if #(.LINES(LINES)) bus ();

  rd_lvl_ctrl #(
    .LINES(LINES), .MAX_DEL(4), .NUM_RD(4), .SETTLE_CYC(8),
    .TIMEOUT(255), .PATTERN(8'hA5)
  ) dut (
    .clk_div        (clk_div),
    .rst_div_n      (rst_div_n),
    .train_start    (train_start),
    .trn            (bus),
    .param_io_in_del(param_io_in_del),
    .sync_en        (sync_en),
    .train_busy     (train_busy),
    .train_done     (train_done),
    .train_fail     (train_fail),
    .fail_mask      (fail_mask),
    .timeout_err    (timeout_err)
  );

  always #5 clk_div = ~clk_div;

  typedef struct {
    string        nm;
    logic         done;
    logic         fail;
    logic         tmo;
    logic         sync;
    logic [15:0]  mask;
    logic [63:0]  del;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Memory model configuration
  logic [4:0] pass_tab [LINES];
  int         ack_dly;
  int         withhold_after;
  int         corrupt_read;
  int         corrupt_line;
  bit         spurious;
  int         reads_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] dels(input int line, input logic [3:0] v);
    logic [63:0] r;
    r = {16{4'h2}};
    if (line >= 0) r[4*line +: 4] = v;
    return r;
  endfunction

  task automatic defaults();
    for (int l = 0; l < LINES; l++) pass_tab[l] = 5'b11111;
    ack_dly        = 0;
    withhold_after = 0;
    corrupt_read   = -1;
    corrupt_line   = 0;
    spurious       = 1'b0;
    reads_done     = 0;
  endtask

  task automatic push_exp(input string nm, input logic done, input logic fail,
                          input logic tmo, input logic sync, input logic [15:0] mask,
                          input logic [63:0] del);
    exp_t e;
    e.nm = nm; e.done = done; e.fail = fail; e.tmo = tmo;
    e.sync = sync; e.mask = mask; e.del = del;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk_div);
    train_start = 1'b1;
    @(negedge clk_div);
    train_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int c = 0; c < 4000 && exp_q.size() != 0; c++) @(negedge clk_div);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_complete: pending=%0d want 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk_div);
  endtask

  task automatic wait_del(input string nm, input logic [3:0] v);
    int c;
    c = 0;
    while (param_io_in_del[3:0] != v && c < 2000) begin
      @(negedge clk_div);
      c++;
    end
    if (c >= 2000) begin
      total++;
      bad++;
      $display("FAIL %s_reach_del: got %h want %h", nm, param_io_in_del[3:0], v);
    end
  endtask

  // Memory / PHY model
  initial begin
    logic [3:0] d;
    logic [7:0] b;
    bus.trn_rd_ack   = 1'b0;
    bus.trn_rd_valid = 1'b0;
    bus.phy_dout     = '0;
    forever begin
      @(negedge clk_div);
      if (rst_div_n && bus.trn_rd_req) begin
        for (int i = 0; i < ack_dly; i++) begin
          if (spurious) begin
            bus.trn_rd_valid = 1'b1;
            bus.phy_dout     = '0;
          end
          @(negedge clk_div);
          chk("req_hold", bus.trn_rd_req, 1);
        end
        bus.trn_rd_ack = 1'b1;
        if (spurious) begin
          bus.trn_rd_valid = 1'b1;
          bus.phy_dout     = '0;
        end
        @(negedge clk_div);
        bus.trn_rd_ack   = 1'b0;
        bus.trn_rd_valid = 1'b0;
        if (ack_dly > 0) chk("req_drop", bus.trn_rd_req, 0);
        if (!(withhold_after > 0 && reads_done == withhold_after)) begin
          @(negedge clk_div);
          d = param_io_in_del[3:0];
          for (int l = 0; l < LINES; l++) begin
            b = pass_tab[l][int'(d)] ? 8'hA5 : 8'h5A;
            if (reads_done == corrupt_read && l == corrupt_line) b = 8'hA4;
            bus.phy_dout[8*l +: 8] = b;
          end
          bus.trn_rd_valid = 1'b1;
          @(negedge clk_div);
          bus.trn_rd_valid = 1'b0;
          reads_done++;
        end
      end
    end
  end

  // Monitor: compare end-of-sweep state against the queued expectation.
  initial begin
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk_div);
      if (rst_div_n && prev_busy && !train_busy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_end: got done=%0b fail=%0b want no completion",
                   train_done, train_fail);
        end else begin
          e = exp_q.pop_front();
          chk({e.nm, "_done"}, train_done, e.done);
          chk({e.nm, "_fail"}, train_fail, e.fail);
          chk({e.nm, "_tmo"},  timeout_err, e.tmo);
          chk({e.nm, "_sync"}, sync_en, e.sync);
          chk({e.nm, "_mask"}, fail_mask, e.mask);
          chk({e.nm, "_del"},  param_io_in_del, e.del);
          chk({e.nm, "_req"},  bus.trn_rd_req, 0);
        end
      end
      prev_busy = train_busy;
    end
  end

  // Stimulus
  initial begin
    defaults();
    repeat (3) @(negedge clk_div);
    chk("rst_del",  param_io_in_del, 0);
    chk("rst_flags", {sync_en, train_busy, train_done, train_fail, timeout_err, bus.trn_rd_req}, 0);
    chk("rst_mask", fail_mask, 0);
    rst_div_n = 1'b1;
    repeat (2) @(negedge clk_div);

    // 1: line 0 passes 1..3, others 0..4; mid-sweep start ignored
    defaults();
    pass_tab[0] = 5'b01110;
    push_exp("s1", 1, 0, 0, 1, 16'h0000, dels(-1, 0));
    pulse_start();
    wait_del("s1", 4'd2);
    pulse_start();
    repeat (2) @(negedge clk_div);
    chk("s1_start_ignored", {train_busy, param_io_in_del[3:0]}, {1'b1, 4'd2});
    wait_done("s1");
    $display("s1 basic sweep: del=%h done=%0b", param_io_in_del, train_done);

    // 2: line 5 passes at 0 and 2 only
    defaults();
    pass_tab[5] = 5'b00101;
    push_exp("s2", 1, 0, 0, 1, 16'h0000, dels(5, 4'd0));
    pulse_start();
    wait_done("s2");
    $display("s2 gapped window: del=%h done=%0b", param_io_in_del, train_done);

    // 3: line 3 never matches
    defaults();
    pass_tab[3] = 5'b00000;
    push_exp("s3", 0, 1, 0, 0, 16'h0008, dels(3, 4'd0));
    pulse_start();
    wait_done("s3");
    $display("s3 dead line: mask=%h fail=%0b", fail_mask, train_fail);

    // 4: one corrupted read at delay 2 on line 7; restart from FAIL clears flags
    defaults();
    corrupt_line = 7;
    corrupt_read = 9;
    push_exp("s4", 1, 0, 0, 1, 16'h0000, dels(7, 4'd0));
    pulse_start();
    @(negedge clk_div);
    chk("s4_restart_clear", {train_busy, train_fail, fail_mask}, {1'b1, 1'b0, 16'h0000});
    wait_done("s4");
    $display("s4 corrupt read: del=%h done=%0b", param_io_in_del, train_done);

    // 5: data withheld after the second read -> timeout
    defaults();
    withhold_after = 2;
    push_exp("s5", 0, 1, 1, 0, 16'h0000, 64'h0);
    pulse_start();
    wait_done("s5");
    $display("s5 timeout: tmo=%0b fail=%0b", timeout_err, train_fail);

    // 6: reset during SETTLE at delay 3, then a slow-ack sweep with stray valids
    defaults();
    pulse_start();
    wait_del("s6", 4'd3);
    repeat (2) @(negedge clk_div);
    rst_div_n = 1'b0;
    #1;
    chk("s6_rst_del", param_io_in_del, 0);
    chk("s6_rst_flags", {sync_en, train_busy, train_done, train_fail, timeout_err, bus.trn_rd_req}, 0);
    repeat (3) @(negedge clk_div);
    rst_div_n = 1'b1;
    defaults();
    ack_dly  = 5;
    spurious = 1'b1;
    push_exp("s6", 1, 0, 0, 1, 16'h0000, dels(-1, 0));
    pulse_start();
    repeat (2) @(negedge clk_div);
    chk("s6_restart_del0", {train_busy, param_io_in_del[3:0]}, {1'b1, 4'd0});
    wait_done("s6");
    $display("s6 reset+slow ack: del=%h done=%0b", param_io_in_del, train_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog");
  end

endmodule
